// File: rtl/char_buffer_reader.sv
// char_buffer_reader
// Streams the character buffer region of data RAM (BUF_LEN entries starting at
// word BASE_ADDR) out one byte at a time over a valid/ready interface.
// Exactly one RAM read is in flight at a time: request, wait one cycle for the
// data, then present the byte until the sink takes it.
//
// Ports:
//   clock, reset      : clock and asynchronous active-low reset
//   start             : one-cycle pulse, begins a pass when idle
//   mem_gnt           : RAM read port granted this cycle
//   mem_rd_en/mem_addr: RAM read request and word address
//   mem_rdata         : RAM read data, valid the cycle after an accepted request
//   char_data/char_valid/char_ready : byte stream towards the display/UART
//   row_last          : presented byte is the last of a ROW_LEN row
//   busy              : pass in progress
//   done              : one-cycle pulse after the final byte is accepted
//
// Optional feature macro: NUL_STOP_EN
//   defined   -> a 0x00 byte ends the pass without being presented
//   undefined -> every one of BUF_LEN bytes is streamed, NULs included
module char_buffer_reader #(
  parameter int unsigned BASE_ADDR = 1500,
  parameter int unsigned BUF_LEN   = 108,
  parameter int unsigned ROW_LEN   = 12,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_gnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              row_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       RC_W     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BUF_LEN - 1);
  localparam logic [RC_W-1:0]   LAST_COL = RC_W'(ROW_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [RC_W-1:0]   row_col_q, row_col_d;
  logic [7:0]        char_data_q, char_data_d;
  logic              row_last_q, row_last_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              char_valid_q, char_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic accept_c;
  logic nul_c;
  logic unused_rdata_c;

  assign accept_c       = char_valid_q && char_ready;
  assign unused_rdata_c = ^mem_rdata[31:8];

`ifdef NUL_STOP_EN
  assign nul_c = (mem_rdata[7:0] == 8'h00);
`else
  assign nul_c = 1'b0;
`endif

  // State, datapath and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      row_col_q    <= '0;
      char_data_q  <= '0;
      row_last_q   <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      row_col_q    <= row_col_d;
      char_data_q  <= char_data_d;
      row_last_q   <= row_last_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      char_valid_q <= char_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next state plus index/column/byte capture
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    row_col_d   = row_col_q;
    char_data_d = char_data_q;
    row_last_d  = row_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d   = '0;
          row_col_d = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (nul_c) begin
          state_d = S_FIN;
        end else begin
          char_data_d = mem_rdata[7:0];
          row_last_d  = (row_col_q == LAST_COL);
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (accept_c) begin
          row_col_d = (row_col_q == LAST_COL) ? '0 : RC_W'(row_col_q + 1'b1);
          if (index_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            index_d = ADDR_W'(index_q + 1'b1);
            state_d = S_ISSUE;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    mem_rd_en_d  = (state_d == S_ISSUE);
    mem_addr_d   = mem_addr_q;
    char_valid_d = (state_d == S_OUT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
    if (state_d == S_ISSUE) mem_addr_d = ADDR_W'(BASE + index_d);
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign row_last   = row_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_char_buffer_reader.sv
module tb_char_buffer_reader;

  localparam int unsigned BASE = 1500;
  localparam int unsigned LEN  = 108;
  localparam int unsigned ROW  = 12;
  localparam int unsigned AW   = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_gnt;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [7:0]    char_data;
  logic          char_valid;
  logic          char_ready;
  logic          row_last;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  char_buffer_reader #(
    .BASE_ADDR(BASE), .BUF_LEN(LEN), .ROW_LEN(ROW), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mem_gnt(mem_gnt),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .row_last(row_last), .busy(busy), .done(done)
  );

  // RAM: data only meaningful the cycle after a granted request
  logic [7:0] ram [0:4095];
  always @(posedge clock) begin
    if (mem_rd_en && mem_gnt) mem_rdata <= {24'($urandom), ram[mem_addr]};
    else                      mem_rdata <= $urandom;
  end

  // Observations of one pass
  logic [7:0]    got_c[$];
  bit            got_rl[$];
  logic [AW-1:0] got_addr[$];
  int            done_cnt, stab_viol, req_out_viol, busy_viol, stall_seen;
  bit            timed_out;
  logic [AW+12:0] snap;

  // Reference: what the buffer should produce
  logic [7:0] exp_c[$];
  bit         exp_rl[$];

  task automatic build_model();
    exp_c.delete();
    exp_rl.delete();
    for (int i = 0; i < int'(LEN); i++) begin
`ifdef NUL_STOP_EN
      if (ram[BASE + i] == 8'h00) break;
`endif
      exp_c.push_back(ram[BASE + i]);
      exp_rl.push_back((i % ROW) == ROW - 1);
    end
  endtask

  task automatic fill_alpha();
    for (int i = 0; i < int'(LEN); i++) ram[BASE + i] = 8'(8'h41 + (i % 26));
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(LEN); i++) ram[BASE + i] = 8'($urandom_range(1, 255));
  endtask

  // Drives one pass and records what the DUT did; no judging here
  task automatic run_pass(input int ready_pct, input int stall_idx, input int stall_len,
                          input int restart_idx, input int abort_idx, input int max_cycles);
    logic [7:0] prev_d;
    bit prev_rl, prev_stall, restarted;
    int post_done;
    got_c.delete(); got_rl.delete(); got_addr.delete();
    done_cnt = 0; stab_viol = 0; req_out_viol = 0; busy_viol = 0; stall_seen = 0;
    timed_out = 1; prev_stall = 0; restarted = 0; post_done = -1;
    prev_d = '0; prev_rl = 0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clock);
      if (post_done == 1 && busy) busy_viol++;
      if (done) begin
        done_cnt++;
        if (post_done < 0) post_done = 0;
      end
      if (post_done < 0 && cyc > 0 && !busy) busy_viol++;
      if (char_valid && mem_rd_en) req_out_viol++;
      if (prev_stall && (!char_valid || char_data !== prev_d || row_last !== prev_rl))
        stab_viol++;
      if (abort_idx >= 0 && got_c.size() == abort_idx && char_valid) begin
        reset = 1'b0;
        #1;
        snap = {mem_rd_en, mem_addr, char_data, char_valid, row_last, busy, done};
        timed_out = 0;
        start = 1'b0;
        return;
      end
      if (cyc == 0) start = 1'b1;
      else if (restart_idx >= 0 && !restarted && got_c.size() == restart_idx) begin
        start = 1'b1;
        restarted = 1;
      end else start = 1'b0;
      mem_gnt = 1'b1;
      if (stall_idx >= 0 && mem_rd_en && mem_addr == AW'(BASE + stall_idx) &&
          stall_seen < stall_len) begin
        mem_gnt = 1'b0;
        stall_seen++;
      end
      if (mem_rd_en && mem_gnt) got_addr.push_back(mem_addr);
      char_ready = ($urandom_range(0, 99) < ready_pct);
      if (char_valid && char_ready) begin
        got_c.push_back(char_data);
        got_rl.push_back(row_last);
      end
      prev_stall = char_valid && !char_ready;
      prev_d = char_data;
      prev_rl = row_last;
      if (post_done >= 0) begin
        if (post_done == 3) begin
          timed_out = 0;
          break;
        end
        post_done++;
      end
    end
    start = 1'b0;
    char_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mem_gnt = 1'b1; char_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_assert++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset mem_rd_en: got %b want 0", mem_rd_en); end
    n_assert++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset mem_addr: got %0d want 0", mem_addr); end
    n_assert++; if (char_data !== 8'h00) begin n_fail++; $display("FAIL reset char_data: got %h want 00", char_data); end
    n_assert++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset char_valid: got %b want 0", char_valid); end
    n_assert++; if (row_last !== 1'b0) begin n_fail++; $display("FAIL reset row_last: got %b want 0", row_last); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_stream();
    fill_alpha();
    build_model();
    run_pass(100, -1, 0, -1, -1, 3000);
    n_assert++; if (timed_out) begin n_fail++; $display("FAIL stream timeout: got no done want done"); end
    n_assert++; if (got_c.size() != exp_c.size()) begin n_fail++; $display("FAIL stream count: got %0d want %0d", got_c.size(), exp_c.size()); end
    for (int i = 0; i < exp_c.size(); i++) begin
      n_assert++;
      if (i >= got_c.size() || got_c[i] !== exp_c[i] || got_rl[i] !== exp_rl[i]) begin
        n_fail++;
        $display("FAIL stream char[%0d]: got %h/%b want %h/%b", i,
                 (i < got_c.size()) ? got_c[i] : 8'hxx, (i < got_rl.size()) ? got_rl[i] : 1'b0,
                 exp_c[i], exp_rl[i]);
      end
    end
    n_assert++; if (got_addr.size() != LEN) begin n_fail++; $display("FAIL stream addr count: got %0d want %0d", got_addr.size(), LEN); end
    for (int i = 0; i < got_addr.size(); i++) begin
      n_assert++;
      if (got_addr[i] !== AW'(BASE + i)) begin n_fail++; $display("FAIL stream addr[%0d]: got %0d want %0d", i, got_addr[i], BASE + i); end
    end
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL stream done pulses: got %0d want 1", done_cnt); end
    n_assert++; if (busy_viol != 0) begin n_fail++; $display("FAIL stream busy: got %0d bad cycles want 0", busy_viol); end
  endtask

  task automatic test_ready_random(input bit random_data);
    int bad;
    if (random_data) fill_random(); else fill_alpha();
    build_model();
    run_pass(45, -1, 0, -1, -1, 4000);
    bad = 0;
    for (int i = 0; i < exp_c.size(); i++)
      if (i >= got_c.size() || got_c[i] !== exp_c[i] || got_rl[i] !== exp_rl[i]) bad++;
    n_assert++; if (timed_out || got_c.size() != exp_c.size() || bad != 0) begin n_fail++; $display("FAIL backpressure seq (rand=%0d): got %0d chars %0d wrong want %0d chars 0 wrong", random_data, got_c.size(), bad, exp_c.size()); end
    n_assert++; if (stab_viol != 0) begin n_fail++; $display("FAIL backpressure stability: got %0d changes want 0", stab_viol); end
    n_assert++; if (req_out_viol != 0) begin n_fail++; $display("FAIL backpressure req while out: got %0d want 0", req_out_viol); end
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL backpressure done pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_grant_stall();
    int bad;
    fill_alpha();
    build_model();
    run_pass(100, 40, 5, -1, -1, 3000);
    n_assert++; if (stall_seen != 5) begin n_fail++; $display("FAIL stall held cycles at 1540: got %0d want 5", stall_seen); end
    bad = 0;
    for (int i = 0; i < got_addr.size(); i++) if (got_addr[i] !== AW'(BASE + i)) bad++;
    n_assert++; if (got_addr.size() != LEN || bad != 0) begin n_fail++; $display("FAIL stall addr seq: got %0d addrs %0d wrong want %0d addrs", got_addr.size(), bad, LEN); end
    bad = 0;
    for (int i = 0; i < exp_c.size(); i++)
      if (i >= got_c.size() || got_c[i] !== exp_c[i] || got_rl[i] !== exp_rl[i]) bad++;
    n_assert++; if (got_c.size() != exp_c.size() || bad != 0) begin n_fail++; $display("FAIL stall stream: got %0d chars %0d wrong want %0d", got_c.size(), bad, exp_c.size()); end
  endtask

  task automatic test_restart_ignored();
    fill_alpha();
    build_model();
    run_pass(100, -1, 0, 10, -1, 3000);
    n_assert++; if (got_c.size() != exp_c.size()) begin n_fail++; $display("FAIL restart count: got %0d want %0d", got_c.size(), exp_c.size()); end
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart done pulses: got %0d want 1", done_cnt); end
    run_pass(100, -1, 0, -1, -1, 3000);
    n_assert++; if (got_addr.size() == 0 || got_addr[0] !== AW'(BASE)) begin n_fail++; $display("FAIL new pass first addr: got %0d want %0d", (got_addr.size() != 0) ? got_addr[0] : '0, BASE); end
    n_assert++; if (got_c.size() != exp_c.size()) begin n_fail++; $display("FAIL new pass count: got %0d want %0d", got_c.size(), exp_c.size()); end
  endtask

  task automatic test_reset_mid();
    int dn;
    fill_alpha();
    build_model();
    run_pass(100, -1, 0, -1, 57, 3000);
    n_assert++; if (timed_out) begin n_fail++; $display("FAIL abort never reached index 57"); end
    n_assert++; if (snap !== '0) begin n_fail++; $display("FAIL abort async outputs: got %h want 0", snap); end
    n_assert++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort done before reset: got %0d want 0", done_cnt); end
    dn = 0;
    repeat (2) begin @(negedge clock); if (done) dn++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clock); if (done || busy) dn++; end
    n_assert++; if (dn != 0) begin n_fail++; $display("FAIL abort done/busy after reset: got %0d cycles want 0", dn); end
    run_pass(100, -1, 0, -1, -1, 3000);
    n_assert++; if (got_addr.size() == 0 || got_addr[0] !== AW'(BASE)) begin n_fail++; $display("FAIL abort restart addr: got %0d want %0d", (got_addr.size() != 0) ? got_addr[0] : '0, BASE); end
    n_assert++; if (got_c.size() != exp_c.size() || done_cnt != 1) begin n_fail++; $display("FAIL abort restart pass: got %0d chars %0d done want %0d chars 1 done", got_c.size(), done_cnt, exp_c.size()); end
  endtask

  task automatic test_nul();
    int want;
    fill_alpha();
    ram[BASE + 5] = 8'h00;
    build_model();
`ifdef NUL_STOP_EN
    want = 5;
`else
    want = int'(LEN);
`endif
    run_pass(100, -1, 0, -1, -1, 3000);
    n_assert++; if (got_c.size() != want || exp_c.size() != want) begin n_fail++; $display("FAIL nul count: got %0d want %0d (model %0d)", got_c.size(), want, exp_c.size()); end
    n_assert++; if (done_cnt != 1) begin n_fail++; $display("FAIL nul done pulses: got %0d want 1", done_cnt); end
    if (got_c.size() > 5) begin
      n_assert++; if (got_c[5] !== 8'h00) begin n_fail++; $display("FAIL nul char5: got %h want 00", got_c[5]); end
    end
    for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
      n_assert++;
      if (got_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL nul char[%0d]: got %h want %h", i, got_c[i], exp_c[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    test_reset();
    test_stream();
    test_ready_random(1'b0);
    test_ready_random(1'b1);
    test_grant_stall();
    test_restart_ignored();
    test_reset_mid();
    test_nul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
